// File: rtl/pq_pkg.sv
// pq_pkg: shared key-value type, empty marker and operation codes for the shift-register priority queue
package pq_pkg;
  localparam int KEY_W = 16;
  localparam int VAL_W = 16;
  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;
  localparam kv_t KV_EMPTY = '{key: '1, val: '0};
  typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_REPLACE} pq_op_t;
endpackage

// File: rtl/sr_pq_ctrl.sv
// sr_pq_ctrl: request/ack front end sequencing enq/deq/replace strobes into a shift-register PQ stage array
// Ports: i_clk, i_rst_n (async active-low); i_enq_req/i_enq_kv/o_enq_ack enqueue handshake;
// i_deq_req/o_deq_ack dequeue handshake, o_deq_valid/o_deq_kv removed entry; i_head_kv stage-1 contents;
// o_pq_enq/o_pq_deq/o_pq_replace/o_pq_kvi stage-array controls; o_count/o_full/o_empty occupancy.
module sr_pq_ctrl
  import pq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enq_req,
  input  kv_t           i_enq_kv,
  output logic          o_enq_ack,
  input  logic          i_deq_req,
  output logic          o_deq_ack,
  output logic          o_deq_valid,
  output kv_t           o_deq_kv,
  input  kv_t           i_head_kv,
  output logic          o_pq_enq,
  output logic          o_pq_deq,
  output logic          o_pq_replace,
  output kv_t           o_pq_kvi,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  state_t        r_state, w_next;
  pq_op_t        r_op, w_op;
  kv_t           r_kvi, r_deq_kv;
  logic          r_deq_valid;
  logic [CW-1:0] r_count;
  logic          w_issue, w_start;
  assign o_full   = r_count == CW'(DEPTH);
  assign o_empty  = r_count == '0;
  assign o_count  = r_count;
  assign o_pq_kvi = r_kvi;
  assign o_deq_valid = r_deq_valid;
  assign o_deq_kv    = r_deq_kv;
  // An enqueue alone against a full array stays pending; paired with a dequeue it becomes a replace.
  always_comb
    w_op = (i_enq_req && i_deq_req) ? OP_REPLACE :
           i_deq_req               ? OP_DEQ :
           (i_enq_req && !o_full)  ? OP_ENQ : OP_NONE;
  assign w_start = r_state == S_IDLE && w_op != OP_NONE;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  always_comb
    w_next = w_start ? S_ISSUE : S_IDLE;
  // Empty-queue deq/replace are acked without touching the stage array.
  always_comb begin
    w_issue      = r_state == S_ISSUE;
    o_pq_enq     = w_issue && r_op == OP_ENQ;
    o_pq_deq     = w_issue && r_op == OP_DEQ && !o_empty;
    o_pq_replace = w_issue && r_op == OP_REPLACE && !o_empty;
    o_enq_ack    = w_issue && (r_op == OP_ENQ || r_op == OP_REPLACE);
    o_deq_ack    = w_issue && (r_op == OP_DEQ || r_op == OP_REPLACE);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_op        <= OP_NONE;
      r_kvi       <= KV_EMPTY;
      r_deq_valid <= 1'b0;
      r_deq_kv    <= KV_EMPTY;
      r_count     <= '0;
    end else begin
      if (w_start) begin
        r_op  <= w_op;
        r_kvi <= i_enq_kv;
      end
      r_deq_valid <= o_deq_ack;
      // head is sampled before the stage array shifts on this same edge
      if (o_deq_ack)
        r_deq_kv <= !o_empty ? i_head_kv : r_op == OP_REPLACE ? r_kvi : KV_EMPTY;
      if (o_pq_enq && !o_full)
        r_count <= r_count + 1'b1;
      else if (o_pq_deq && !o_empty)
        r_count <= r_count - 1'b1;
    end
endmodule

// File: tb/tb_sr_pq_ctrl.sv
// tb_sr_pq_ctrl: directed bench for sr_pq_ctrl with a sorted stage-array model
module tb_sr_pq_ctrl;
  import pq_pkg::*;
  logic       i_clk = 1'b0, i_rst_n = 1'b0;
  logic       i_enq_req = 1'b0, i_deq_req = 1'b0;
  kv_t        i_enq_kv = KV_EMPTY, i_head_kv;
  logic       o_enq_ack, o_deq_ack, o_deq_valid, o_pq_enq, o_pq_deq, o_pq_replace, o_full, o_empty;
  kv_t        o_deq_kv, o_pq_kvi;
  logic [2:0] o_count;
  int         nvec = 0, nerr = 0;
  kv_t        m[4];
  int         mcnt;
  always #5 i_clk = ~i_clk;
  sr_pq_ctrl #(.DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enq_req(i_enq_req), .i_enq_kv(i_enq_kv),
    .o_enq_ack(o_enq_ack), .i_deq_req(i_deq_req), .o_deq_ack(o_deq_ack),
    .o_deq_valid(o_deq_valid), .o_deq_kv(o_deq_kv), .i_head_kv(i_head_kv),
    .o_pq_enq(o_pq_enq), .o_pq_deq(o_pq_deq), .o_pq_replace(o_pq_replace),
    .o_pq_kvi(o_pq_kvi), .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );
  always @(posedge i_clk or negedge i_rst_n) begin : model
    kv_t t[4];
    int  n, j;
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) m[i] <= KV_EMPTY;
      mcnt <= 0;
    end else begin
      t = m;
      n = mcnt;
      if (o_pq_deq || o_pq_replace) begin
        for (int i = 0; i < 3; i++) t[i] = t[i+1];
        t[3] = KV_EMPTY;
        n--;
      end
      if ((o_pq_enq || o_pq_replace) && n < 4) begin
        j = n;
        while (j > 0 && t[j-1].key > o_pq_kvi.key) begin
          t[j] = t[j-1];
          j--;
        end
        t[j] = o_pq_kvi;
        n++;
      end
      m <= t;
      mcnt <= n;
    end
  end
  assign i_head_kv = m[0];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic kv_t mk(input int k);
    return '{key: 16'(k), val: 16'(k + 256)};
  endfunction
  logic       ea, da, dv;
  kv_t        dkv, kvi;
  int         ns, lat;
  logic [2:0] sk;
  task automatic op(input logic e, input logic d, input int k);
    @(negedge i_clk);
    i_enq_req = e;
    i_deq_req = d;
    i_enq_kv  = mk(k);
    ea = 0; da = 0; ns = 0; lat = 0; sk = 0; kvi = KV_EMPTY;
    for (int c = 1; c <= 20 && !(ea || da); c++) begin
      @(posedge i_clk); #1;
      ns += int'(o_pq_enq) + int'(o_pq_deq) + int'(o_pq_replace);
      sk |= {o_pq_enq, o_pq_deq, o_pq_replace};
      ea = o_enq_ack; da = o_deq_ack; lat = c; kvi = o_pq_kvi;
    end
    if (!(ea || da)) chk("ack_timeout", 0, 1);
    i_enq_req = 0;
    i_deq_req = 0;
    @(posedge i_clk); #1;
    ns += int'(o_pq_enq) + int'(o_pq_deq) + int'(o_pq_replace);
    dv = o_deq_valid;
    dkv = o_deq_kv;
  endtask
  task automatic enq(input int k);
    op(1, 0, k);
    chk($sformatf("enq%0d_ack", k), {ea, da}, 2'b10);
    chk($sformatf("enq%0d_strobe", k), {29'(ns), sk}, {29'd1, 3'b100});
    chk($sformatf("enq%0d_kvi", k), kvi, mk(k));
    chk($sformatf("enq%0d_lat", k), lat, 1);
  endtask
  task automatic deq(input int k);
    op(0, 1, 0);
    chk($sformatf("deq%0d_ack", k), {ea, da, dv}, 3'b011);
    chk($sformatf("deq%0d_kv", k), dkv, mk(k));
    chk($sformatf("deq%0d_strobe", k), {29'(ns), sk}, {29'd1, 3'b010});
  endtask
  int acks;
  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_count", o_count, 0);
    chk("rst_flags", {o_full, o_empty}, 2'b01);
    chk("rst_outs", {o_enq_ack, o_deq_ack, o_deq_valid, o_pq_enq, o_pq_deq, o_pq_replace}, 0);
    chk("rst_deq_kv", o_deq_kv, KV_EMPTY);
    chk("rst_pq_kvi", o_pq_kvi, KV_EMPTY);
    @(negedge i_clk);
    i_rst_n = 1;
    enq(5); enq(2); enq(9); enq(7);
    chk("fill_count", o_count, 4);
    chk("fill_flags", {o_full, o_empty}, 2'b10);
    chk("fill_head", i_head_kv.key, 2);
    deq(2); deq(5); deq(7); deq(9);
    chk("drain_count", o_count, 0);
    chk("drain_flags", {o_full, o_empty}, 2'b01);
    enq(9); enq(5); enq(2); enq(7);
    @(negedge i_clk);
    i_enq_req = 1;
    i_enq_kv  = mk(1);
    acks = 0;
    repeat (10) begin
      @(posedge i_clk); #1;
      acks += int'(o_enq_ack) + int'(o_pq_enq) + int'(o_pq_replace);
    end
    chk("full_hold_acks", acks, 0);
    chk("full_hold_count", o_count, 4);
    op(1, 1, 1);
    chk("full_rep_ack", {ea, da, dv}, 3'b111);
    chk("full_rep_kv", dkv, mk(2));
    chk("full_rep_count", o_count, 4);
    chk("full_rep_head", i_head_kv.key, 1);
    deq(1); deq(5); deq(7); deq(9);
    enq(3); enq(8);
    op(1, 1, 1);
    chk("rep_ack", {ea, da, dv}, 3'b111);
    chk("rep_strobe", {29'(ns), sk}, {29'd1, 3'b001});
    chk("rep_kv", dkv, mk(3));
    chk("rep_count", o_count, 2);
    chk("rep_head", i_head_kv.key, 1);
    deq(1); deq(8);
    op(0, 1, 0);
    chk("mt_deq_ack", {ea, da, dv}, 3'b011);
    chk("mt_deq_kv", dkv, KV_EMPTY);
    chk("mt_deq_strobe", ns, 0);
    chk("mt_deq_count", o_count, 0);
    op(1, 1, 4);
    chk("mt_rep_ack", {ea, da, dv}, 3'b111);
    chk("mt_rep_kv", dkv, mk(4));
    chk("mt_rep_strobe", ns, 0);
    chk("mt_rep_count", {o_count, o_empty}, {3'd0, 1'b1});
    @(negedge i_clk);
    i_enq_req = 1;
    i_enq_kv  = mk(6);
    @(posedge i_clk); #1;
    chk("mid_issue", {o_pq_enq, o_enq_ack}, 2'b11);
    i_rst_n = 0;
    #1;
    chk("mid_rst_outs", {o_enq_ack, o_deq_ack, o_deq_valid, o_pq_enq, o_pq_deq, o_pq_replace}, 0);
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_kvi", o_pq_kvi, KV_EMPTY);
    i_enq_req = 0;
    @(posedge i_clk); #1;
    chk("mid_rst_after", {o_enq_ack, o_deq_valid, o_count}, 0);
    @(negedge i_clk);
    i_rst_n = 1;
    enq(4);
    chk("recover_count", o_count, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
